// File: rtl/slave_wr_back_async_fifo_if.sv
// Write-back FIFO handshake bundle: write side (data/en/full/almost_full)
// and read side (en/data/empty/almost_empty); master drives, slave is the FIFO.
interface slave_wr_back_async_fifo_if #(
    parameter int DATA_WIDTH = 11
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  wr_full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_empty;
    logic                  almost_empty;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, almost_full, rd_data, rd_empty, almost_empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, almost_full, rd_data, rd_empty, almost_empty
    );
endinterface

// File: rtl/slave_wr_back_async_fifo.sv
// Dual-clock write-back FIFO, Gray pointers with 2-flop synchronizers.
// Ports: wr_clk/rd_clk, wr_rst/rd_rst (async, active-high), bus (slave).
module slave_wr_back_async_fifo #(
    parameter int DATA_WIDTH       = 11,
    parameter int ADDR_WIDTH       = 10,
    parameter int ALMOST_FULL_NUM  = 20,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input logic wr_clk,
    input logic rd_clk,
    input logic wr_rst,
    input logic rd_rst,
    slave_wr_back_async_fifo_if.slave bus
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // write domain
    logic          wr_fire;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rq1_q, rq2_q;
    logic [PW-1:0] wlevel;
    logic          wr_full_q, wr_full_d;
    logic          almost_full_q, almost_full_d;

    // read domain
    logic                  rd_fire;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         rgray_q, rgray_d;
    logic [PW-1:0]         wq1_q, wq2_q;
    logic [PW-1:0]         rlevel;
    logic                  rd_empty_q, rd_empty_d;
    logic                  almost_empty_q, almost_empty_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Flags are computed from the post-update pointer so a write that
    // fills the FIFO (or a read that empties it) is reflected at once.
    always_comb begin
        wr_fire       = bus.wr_en & ~wr_full_q;
        wptr_d        = wptr_q + PW'(wr_fire);
        wgray_d       = wptr_d ^ (wptr_d >> 1);
        wr_full_d     = (wgray_d == {~rq2_q[PW-1:PW-2], rq2_q[PW-3:0]});
        wlevel        = wptr_d - gray2bin(rq2_q);
        almost_full_d = (wlevel >= PW'(ALMOST_FULL_NUM));
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wptr_q        <= '0;
            wgray_q       <= '0;
            rq1_q         <= '0;
            rq2_q         <= '0;
            wr_full_q     <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            wgray_q       <= wgray_d;
            rq1_q         <= rgray_q;
            rq2_q         <= rq1_q;
            wr_full_q     <= wr_full_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Storage is never reset; only the pointers are.
    always_ff @(posedge wr_clk) begin
        if (wr_fire) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    always_comb begin
        rd_fire        = bus.rd_en & ~rd_empty_q;
        rptr_d         = rptr_q + PW'(rd_fire);
        rgray_d        = rptr_d ^ (rptr_d >> 1);
        rd_empty_d     = (rgray_d == wq2_q);
        rlevel         = gray2bin(wq2_q) - rptr_d;
        almost_empty_d = (rlevel <= PW'(ALMOST_EMPTY_NUM));
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rptr_q         <= '0;
            rgray_q        <= '0;
            wq1_q          <= '0;
            wq2_q          <= '0;
            rd_empty_q     <= 1'b1;
            almost_empty_q <= 1'b1;
        end else begin
            rptr_q         <= rptr_d;
            rgray_q        <= rgray_d;
            wq1_q          <= wgray_q;
            wq2_q          <= wq1_q;
            rd_empty_q     <= rd_empty_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    // Read data holds its last value when no read is accepted.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_data_q <= '0;
        end else if (rd_fire) begin
            rd_data_q <= mem[rptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign bus.wr_full      = wr_full_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_empty     = rd_empty_q;
    assign bus.almost_empty = almost_empty_q;
endmodule

// File: tb/tb_slave_wr_back_async_fifo.sv
// Bench for slave_wr_back_async_fifo: scoreboard queue fed on accepted
// writes, monitor pops on accepted reads; directed flag checks per phase.
module tb_slave_wr_back_async_fifo;
    logic clk = 1'b0;
    logic tb_rst = 1'b1;

    always #5 clk = ~clk;

    slave_wr_back_async_fifo_if #(.DATA_WIDTH(11)) bus ();

    slave_wr_back_async_fifo dut (
        .wr_clk (clk),
        .rd_clk (clk),
        .wr_rst (tb_rst),
        .rd_rst (tb_rst),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [10:0] sbq[$];
    bit pend = 1'b0;
    bit chk_nofull = 1'b0;
    int n_pushed = 0;
    int n_read = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: inputs change just after posedge, so the
    // negedge sees exactly what the next edge will act on.
    always @(negedge clk) begin
        logic [10:0] exp;
        if (tb_rst) begin
            sbq.delete();
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (sbq.size() == 0) begin
                    chk("rd_unexpected", 32'(bus.rd_data), 32'hFFFF_FFFF);
                end else begin
                    exp = sbq.pop_front();
                    chk("rd_data", 32'(bus.rd_data), 32'(exp));
                    n_read++;
                end
            end
            pend = bus.rd_en && !bus.rd_empty;
            if (bus.wr_en && !bus.wr_full) begin
                sbq.push_back(bus.wr_data);
                n_pushed++;
            end
            if (chk_nofull) chk("never_full", 32'(bus.wr_full), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 11'($urandom);
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic rd_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rd_en = 1'b1;
            tick();
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic chk_reset_flags(input string tag);
        chk({tag, "_rd_empty"}, 32'(bus.rd_empty), 1);
        chk({tag, "_almost_empty"}, 32'(bus.almost_empty), 1);
        chk({tag, "_wr_full"}, 32'(bus.wr_full), 0);
        chk({tag, "_almost_full"}, 32'(bus.almost_full), 0);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, rem, cyc, p0, r0, tgt;
        logic [10:0] d;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        #200;
        tick();
        tb_rst = 1'b0;
        idle(2);
        chk_reset_flags("reset");

        // Fill: 1025 writes, last one must be dropped.
        for (int i = 0; i <= 1024; i++) begin
            d = 11'h7FF - 11'(i);
            bus.wr_en   = 1'b1;
            bus.wr_data = d;
            tick();
            k = i + 1;
            chk("fill_full", 32'(bus.wr_full), 32'(k >= 1024));
            chk("fill_afull", 32'(bus.almost_full), 32'(k >= 20));
            if (k <= 2) chk("fill_empty_early", 32'(bus.rd_empty), 1);
            if (k >= 6) chk("fill_empty_late", 32'(bus.rd_empty), 0);
        end
        bus.wr_en = 1'b0;
        idle(2);
        chk("fill_count", 32'(sbq.size()), 1024);

        // Drain: 1025 reads, last one must be ignored.
        for (int i = 0; i <= 1024; i++) begin
            bus.rd_en = 1'b1;
            tick();
            rem = (i >= 1023) ? 0 : 1023 - i;
            chk("drain_empty", 32'(bus.rd_empty), 32'(rem == 0));
            chk("drain_aempty", 32'(bus.almost_empty), 32'(rem <= 4));
        end
        bus.rd_en = 1'b0;
        idle(6);
        chk("drain_hold", 32'(bus.rd_data), 32'h400);
        chk("drain_left", 32'(sbq.size()), 0);
        chk("drain_full", 32'(bus.wr_full), 0);
        chk("drain_afull", 32'(bus.almost_full), 0);

        // Thresholds.
        wr_n(4);
        idle(6);
        chk("thr_ae_at4", 32'(bus.almost_empty), 1);
        chk("thr_ne_at4", 32'(bus.rd_empty), 0);
        wr_n(1);
        idle(6);
        chk("thr_ae_at5", 32'(bus.almost_empty), 0);
        wr_n(14);
        chk("thr_af_at19", 32'(bus.almost_full), 0);
        wr_n(1);
        chk("thr_af_at20", 32'(bus.almost_full), 1);
        idle(4);
        rd_n(20);
        idle(4);
        chk("thr_left", 32'(sbq.size()), 0);
        chk("thr_empty", 32'(bus.rd_empty), 1);

        // Concurrent streaming across pointer wrap.
        p0 = n_pushed;
        r0 = n_read;
        wr_n(8);
        tgt = n_pushed + 3000;
        chk_nofull = 1'b1;
        cyc = 0;
        while (n_pushed < tgt && cyc < 20000) begin
            bus.wr_en   = ($urandom_range(0, 3) != 0);
            bus.rd_en   = ($urandom_range(0, 3) != 0);
            bus.wr_data = 11'($urandom);
            tick();
            cyc++;
        end
        chk("conc_bound", 32'(cyc < 20000), 1);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        cyc = 0;
        while ((sbq.size() != 0 || pend) && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk("conc_drain_bound", 32'(cyc < 2000), 1);
        idle(4);
        chk_nofull = 1'b0;
        chk("conc_no_loss", 32'(n_read - r0), 32'(n_pushed - p0));
        chk("conc_pushed", 32'(n_pushed - p0), 3008);
        chk("conc_empty", 32'(bus.rd_empty), 1);

        // Mid-run reset with FIFO half full.
        wr_n(512);
        idle(5);
        chk("mid_afull", 32'(bus.almost_full), 1);
        @(posedge clk);
        #3;
        tb_rst = 1'b1;
        #4;
        chk_reset_flags("mid_in_rst");
        idle(3);
        tb_rst = 1'b0;
        idle(3);
        chk_reset_flags("mid_after");
        wr_n(3);
        idle(6);
        chk("mid_ne", 32'(bus.rd_empty), 0);
        r0 = n_read;
        rd_n(3);
        idle(3);
        chk("mid_reads", 32'(n_read - r0), 3);
        chk("mid_left", 32'(sbq.size()), 0);
        chk("mid_empty", 32'(bus.rd_empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
